// File: rtl/can_frame_pkg.sv
// rtl/can_frame_pkg.sv - shared state encoding, field lengths and helpers for the CAN receive sequencer
package can_frame_pkg;

  // Field order of the incoming frame. The stuffed region spans ST_BASE_ID through ST_CRC,
  // so the enum order matters: the region check is a range compare.
  typedef enum logic [4:0] {
    ST_IDLE,
    ST_BASE_ID,
    ST_SRR_RTR,
    ST_IDE,
    ST_EXT_ID,
    ST_RTR,
    ST_R1,
    ST_R0,
    ST_DLC,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK_SLOT,
    ST_ACK_DEL,
    ST_EOF,
    ST_IFS,
    ST_ERR_WAIT
  } state_t;

  localparam int unsigned FLD_W  = 5;
  localparam int unsigned DATA_W = 7;

  localparam logic [FLD_W-1:0] BASE_ID_LEN  = 5'd11;
  localparam logic [FLD_W-1:0] EXT_ID_LEN   = 5'd18;
  localparam logic [FLD_W-1:0] DLC_LEN      = 5'd4;
  localparam logic [FLD_W-1:0] CRC_LEN      = 5'd15;
  localparam logic [FLD_W-1:0] EOF_LEN      = 5'd7;
  localparam logic [FLD_W-1:0] IFS_LEN      = 5'd3;
  localparam logic [FLD_W-1:0] ERR_IDLE_LEN = 5'd11;

  localparam int unsigned STORAGE_W = 590;

  // Data-field length in bits: remote frames carry none, larger DLC codes clamp to max_bytes.
  function automatic logic [DATA_W-1:0] data_bits(input logic       is_rtr,
                                                  input logic [3:0] dlc_val,
                                                  input logic [3:0] max_bytes);
    logic [3:0] nb;
    nb = (dlc_val > max_bytes) ? max_bytes : dlc_val;
    if (is_rtr) nb = 4'd0;
    return {nb, 3'b000};
  endfunction

endpackage

// File: rtl/can_field_counter.sv
// rtl/can_field_counter.sv - loadable down-counter holding the remaining bits of the current field
//   clk, reset : clock, synchronous active-high reset
//   en         : one accepted (non-stuff) bit this clk
//   load       : reload with load_val instead of counting (only when en)
//   load_val   : field length to load
//   tc         : current bit is the last bit of the field
module can_field_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (load) begin
        count <= load_val;
      end else if (count != '0) begin
        count <= count - W'(1);
      end
    end
  end

  assign tc = (count == W'(1));

endmodule

// File: rtl/can_rx_frame_sequencer.sv
// rtl/can_rx_frame_sequencer.sv - CAN receive field sequencer driving the frame storage register
//   clk, reset   : clock, synchronous active-high reset
//   sp           : sample-point strobe, one clk wide
//   can_rx       : sampled bus bit (0 = dominant)
//   is_stuff     : current bit is a stuff bit (honoured only SOF..CRC)
//   store_en     : pulse, shift can_rx into storage
//   storage_clr  : pulse, clear storage
//   bit_idx      : bits stored in the current frame
//   ide, rtr, dlc: latched header fields, cleared on SOF
//   ack_slot     : high for the ACK-slot bit period
//   frame_done   : pulse after EOF bit 7
//   form_err     : pulse on a fixed-form field violation
module can_rx_frame_sequencer
  import can_frame_pkg::*;
#(
  parameter int MAX_DATA_BYTES = 8,
  parameter int IDX_W          = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sp,
  input  logic             can_rx,
  input  logic             is_stuff,
  output logic             store_en,
  output logic             storage_clr,
  output logic [IDX_W-1:0] bit_idx,
  output logic             ide,
  output logic             rtr,
  output logic [3:0]       dlc,
  output logic             ack_slot,
  output logic             frame_done,
  output logic             form_err
);

  localparam logic [3:0] MAX_B = 4'(MAX_DATA_BYTES);

  state_t              state, state_n;
  logic                in_region, adv;
  logic                store, sof, err, done;
  logic                lat_srr, lat_ide, lat_rtr, lat_dlc;
  logic                srr_bit;
  logic                fld_load, fld_tc, dat_load, dat_tc;
  logic [FLD_W-1:0]    fld_val;
  logic [DATA_W-1:0]   dat_val, n_bits;
  logic [3:0]          dlc_full;

  // Stuff bits only exist between SOF and the last CRC bit; elsewhere is_stuff is noise.
  assign in_region = (state >= ST_BASE_ID) && (state <= ST_CRC);
  assign adv       = sp && !(is_stuff && in_region);

  // DLC shifts in MSB first; on its last bit the full code is the old 3 LSBs plus the live bit.
  assign dlc_full  = {dlc[2:0], can_rx};
  assign n_bits    = data_bits(rtr, dlc_full, MAX_B);

  can_field_counter #(.W(FLD_W)) u_fld_cnt (
    .clk      (clk),
    .reset    (reset),
    .en       (adv),
    .load     (fld_load),
    .load_val (fld_val),
    .tc       (fld_tc)
  );

  can_field_counter #(.W(DATA_W)) u_dat_cnt (
    .clk      (clk),
    .reset    (reset),
    .en       (adv),
    .load     (dat_load),
    .load_val (dat_val),
    .tc       (dat_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    store    = 1'b0;
    sof      = 1'b0;
    err      = 1'b0;
    done     = 1'b0;
    lat_srr  = 1'b0;
    lat_ide  = 1'b0;
    lat_rtr  = 1'b0;
    lat_dlc  = 1'b0;
    fld_load = 1'b0;
    fld_val  = '0;
    dat_load = 1'b0;
    dat_val  = '0;
    if (adv) begin
      unique case (state)
        ST_IDLE:     if (!can_rx) sof = 1'b1;
        ST_BASE_ID:  begin store = 1'b1; if (fld_tc) state_n = ST_SRR_RTR; end
        ST_SRR_RTR:  begin store = 1'b1; lat_srr = 1'b1; state_n = ST_IDE; end
        ST_IDE: begin
          store   = 1'b1;
          lat_ide = 1'b1;
          if (can_rx) begin
            state_n  = ST_EXT_ID;
            fld_load = 1'b1;
            fld_val  = EXT_ID_LEN;
          end else begin
            state_n = ST_R0;
          end
        end
        ST_EXT_ID:   begin store = 1'b1; if (fld_tc) state_n = ST_RTR; end
        ST_RTR:      begin store = 1'b1; lat_rtr = 1'b1; state_n = ST_R1; end
        ST_R1:       begin store = 1'b1; state_n = ST_R0; end
        ST_R0: begin
          store    = 1'b1;
          state_n  = ST_DLC;
          fld_load = 1'b1;
          fld_val  = DLC_LEN;
        end
        ST_DLC: begin
          store   = 1'b1;
          lat_dlc = 1'b1;
          if (fld_tc) begin
            if (n_bits == '0) begin
              state_n  = ST_CRC;
              fld_load = 1'b1;
              fld_val  = CRC_LEN;
            end else begin
              state_n  = ST_DATA;
              dat_load = 1'b1;
              dat_val  = n_bits;
            end
          end
        end
        ST_DATA: begin
          store = 1'b1;
          if (dat_tc) begin
            state_n  = ST_CRC;
            fld_load = 1'b1;
            fld_val  = CRC_LEN;
          end
        end
        ST_CRC:      begin store = 1'b1; if (fld_tc) state_n = ST_CRC_DEL; end
        ST_CRC_DEL:  if (can_rx) state_n = ST_ACK_SLOT; else err = 1'b1;
        ST_ACK_SLOT: state_n = ST_ACK_DEL;
        ST_ACK_DEL: begin
          if (can_rx) begin
            state_n  = ST_EOF;
            fld_load = 1'b1;
            fld_val  = EOF_LEN;
          end else begin
            err = 1'b1;
          end
        end
        ST_EOF: begin
          // A dominant last EOF bit is an overload indication, not a form error.
          if (fld_tc) begin
            done     = 1'b1;
            state_n  = ST_IFS;
            fld_load = 1'b1;
            fld_val  = IFS_LEN;
          end else if (!can_rx) begin
            err = 1'b1;
          end
        end
        ST_IFS: begin
          // Dominant on the last IFS bit is the next frame's SOF.
          if (!can_rx) begin
            if (fld_tc) sof = 1'b1;
            else        err = 1'b1;
          end else if (fld_tc) begin
            state_n = ST_IDLE;
          end
        end
        ST_ERR_WAIT: begin
          if (!can_rx) begin
            fld_load = 1'b1;
            fld_val  = ERR_IDLE_LEN;
          end else if (fld_tc) begin
            state_n = ST_IDLE;
          end
        end
        default:     state_n = ST_IDLE;
      endcase
    end
    if (sof) begin
      state_n  = ST_BASE_ID;
      store    = 1'b1;
      fld_load = 1'b1;
      fld_val  = BASE_ID_LEN;
    end
    if (err) begin
      state_n  = ST_ERR_WAIT;
      fld_load = 1'b1;
      fld_val  = ERR_IDLE_LEN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      store_en    <= 1'b0;
      storage_clr <= 1'b0;
      frame_done  <= 1'b0;
      form_err    <= 1'b0;
      ack_slot    <= 1'b0;
      bit_idx     <= '0;
      ide         <= 1'b0;
      rtr         <= 1'b0;
      dlc         <= 4'd0;
      srr_bit     <= 1'b0;
    end else begin
      store_en    <= store;
      storage_clr <= sof || err;
      frame_done  <= done;
      form_err    <= err;
      ack_slot    <= (state_n == ST_ACK_SLOT);
      if (sof) begin
        bit_idx <= IDX_W'(1);
        ide     <= 1'b0;
        rtr     <= 1'b0;
        dlc     <= 4'd0;
      end else begin
        if (err)        bit_idx <= '0;
        else if (store) bit_idx <= bit_idx + IDX_W'(1);
        if (lat_srr) srr_bit <= can_rx;
        // Standard frames carry RTR in the SRR_RTR slot; commit it once IDE confirms the format.
        if (lat_ide) begin
          ide <= can_rx;
          if (!can_rx) rtr <= srr_bit;
        end
        if (lat_rtr) rtr <= can_rx;
        if (lat_dlc) dlc <= dlc_full;
      end
    end
  end

endmodule
